ps2_host_tx: RTL

- PS/2 host-to-device transmitter. It is the outbound companion of the PS2Keyboard receiver inside AppleIO.
- Sends single command bytes to the keyboard (LED update 0xED, reset 0xFF, typematic 0xF3, ...) over the same open-collector PS2Clk/PS2Din lines.
- Implements the PS/2 request-to-send, bit shifting on device-generated clock edges, odd parity, ACK check and timeouts.
- Asserts busy so the keyboard receiver can ignore the frame.

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_host_tx_if.sv | 26 ++
 rtl/ps2_line_sync.sv | 38 +++
 rtl/ps2_host_tx.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, command bytes and timing defaults.
// The keyboard receiver imports the same package.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SHIFT,
        STOP,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_ACK        = 8'hFA;

    // Timing defaults for a 50 MHz clk.
    localparam int PS2_INHIBIT_CYCLES = 5000;    // 100 us
    localparam int PS2_START_TIMEOUT  = 750000;  // 15 ms
    localparam int PS2_BIT_TIMEOUT    = 100000;  // 2 ms
    localparam int PS2_SYNC_STAGES    = 2;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake plus open-collector line signals of the PS/2 transmitter.
interface ps2_host_tx_if;

    logic [7:0] txData;
    logic       txStart;
    logic       busy;
    logic       done;
    logic       error;
    logic       ps2ClkIn;
    logic       ps2DatIn;
    logic       ps2ClkDrvLow;
    logic       ps2DatDrvLow;

    // Environment side: issues commands and presents the line levels.
    modport master (
        output txData, txStart, ps2ClkIn, ps2DatIn,
        input  busy, done, error, ps2ClkDrvLow, ps2DatDrvLow
    );

    // Transmitter side.
    modport slave (
        input  txData, txStart, ps2ClkIn, ps2DatIn,
        output busy, done, error, ps2ClkDrvLow, ps2DatDrvLow
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Synchronizes the PS/2 clock and data lines into clk and flags device
// falling clock edges. Shared with the keyboard receiver.
module ps2_line_sync #(
    parameter int STAGES = 2  // must be at least 2
) (
    input  logic clk,
    input  logic cpuRstN,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_level,
    output logic dat_level,
    output logic clk_fall
);

    logic [STAGES-1:0] clk_q;
    logic [STAGES-1:0] dat_q;
    logic              clk_prev;

    // Synchronizer chains; reset to the idle (released, high) line level so
    // leaving reset never looks like a falling edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge cpuRstN) begin
        if (!cpuRstN) begin
            clk_q    <= '1;
            dat_q    <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_q    <= {clk_q[STAGES-2:0], ps2_clk};
            dat_q    <= {dat_q[STAGES-2:0], ps2_dat};
            clk_prev <= clk_q[STAGES-1];
        end
    end

    assign clk_level = clk_q[STAGES-1];
    assign dat_level = dat_q[STAGES-1];
    assign clk_fall  = clk_prev & ~clk_q[STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shifting on device
// clock falling edges, odd parity, ACK check and timeouts.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
    parameter int BIT_TIMEOUT    = PS2_BIT_TIMEOUT,
    parameter int SYNC_STAGES    = PS2_SYNC_STAGES
) (
    input logic          clk,
    input logic          cpuRstN,
    ps2_host_tx_if.slave bus
);

    localparam int TMAX0 = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
    localparam int TMAX  = (TMAX0 > INHIBIT_CYCLES) ? TMAX0 : INHIBIT_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    ps2_state_e    state;
    ps2_state_e    state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_load;
    logic [8:0]    shift_q;
    logic [3:0]    bit_cnt;
    logic          dat_low;
    logic          clk_level;
    logic          dat_level;
    logic          clk_fall;
    logic          timeout;
    logic          frame_active;

    ps2_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .cpuRstN   (cpuRstN),
        .ps2_clk   (bus.ps2ClkIn),
        .ps2_dat   (bus.ps2DatIn),
        .clk_level (clk_level),
        .dat_level (dat_level),
        .clk_fall  (clk_fall)
    );

    assign timeout      = (timer == '0);
    // States in which the device is clocking; our own clock pull-down in
    // INHIBIT also produces a falling edge, which must not reload the timer.
    assign frame_active = (state == SHIFT) || (state == STOP) ||
                          (state == ACK)   || (state == WAIT_IDLE);

    // State register; reset drops straight back to IDLE, releasing both lines.
    always_ff @(posedge clk or negedge cpuRstN) begin
        if (!cpuRstN) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic: frame sequencing and timeout handling.
    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.txStart) state_next = INHIBIT;
            INHIBIT:   if (timeout) state_next = SHIFT;
            SHIFT: begin
                if (clk_fall) begin
                    if (bit_cnt == 4'd8) state_next = STOP;  // parity bit now on the line
                end else if (timeout) begin
                    state_next = ERR;
                end
            end
            STOP: begin
                if (clk_fall)     state_next = ACK;          // stop bit: data released
                else if (timeout) state_next = ERR;
            end
            ACK: begin
                if (clk_fall)     state_next = dat_level ? ERR : WAIT_IDLE;
                else if (timeout) state_next = ERR;
            end
            WAIT_IDLE: begin
                if (clk_level && dat_level) state_next = DONE;
                else if (timeout)           state_next = ERR;
            end
            DONE, ERR: state_next = IDLE;
        endcase
    end

    // Timer reload value for the state being entered.
    always_comb begin
        case (state_next)
            INHIBIT: timer_load = TW'(INHIBIT_CYCLES - 1);  // clock low exactly INHIBIT_CYCLES
            SHIFT:   timer_load = TW'(START_TIMEOUT);
            default: timer_load = TW'(BIT_TIMEOUT);
        endcase
    end

    // Datapath: down-counter, byte/parity shift register, bit count, data drive.
    always_ff @(posedge clk or negedge cpuRstN) begin
        if (!cpuRstN) begin
            timer   <= '0;
            shift_q <= '0;
            bit_cnt <= '0;
            dat_low <= 1'b0;
        end else begin
            if (state_next != state)
                timer <= timer_load;
            else if (clk_fall && frame_active)
                timer <= TW'(BIT_TIMEOUT);
            else if (!timeout)
                timer <= timer - TW'(1);

            if (state == IDLE && bus.txStart) begin
                shift_q <= {odd_parity(bus.txData), bus.txData};
                bit_cnt <= '0;
            end else if (state == INHIBIT && state_next == SHIFT) begin
                dat_low <= 1'b1;  // hold the start bit until the first falling edge
            end else if (state == SHIFT && clk_fall) begin
                dat_low <= ~shift_q[0];
                shift_q <= {1'b0, shift_q[8:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Outputs decoded from state; ERR, DONE and IDLE leave both lines released.
    always_comb begin
        bus.busy         = (state != IDLE);
        bus.done         = (state == DONE);
        bus.error        = (state == ERR);
        bus.ps2ClkDrvLow = (state == INHIBIT);
        bus.ps2DatDrvLow = ((state == INHIBIT) && timeout) ||
                           (((state == SHIFT) || (state == STOP)) && dat_low);
    end

endmodule
